// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and counter width helpers for the UART.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

   function automatic int baud_cnt_w(input int clks_per_bit);
      return $clog2(clks_per_bit);
   endfunction

   function automatic int bit_cnt_w(input int data_bits);
      return $clog2(data_bits + 1);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive byte buffer; pointers carry a wrap bit to tell full from empty.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = wr_ptr == rd_ptr;
   assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
   assign do_pop  = pop && !empty;
   // a pop frees the slot in the same cycle, so a full FIFO still accepts
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      end

   always_ff @(posedge clock)
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;

endmodule

// File: rtl/uart_port.sv
// uart_port: UART transceiver with valid/ready byte ports and buffered RX path.
// Even parity bit in both directions when UART_PARITY_EN is defined.
module uart_port
   import uart_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int CLKS_PER_BIT  = 16,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 uart_rx_i,
   output logic                 uart_tx_o,
   input  logic [DATA_BITS-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 rx_overrun_o,
   output logic                 rx_frame_err_o,
   output logic                 rx_parity_err_o
);

   localparam int BAUD_CNT_W = baud_cnt_w(CLKS_PER_BIT);
   localparam int BIT_CNT_W  = bit_cnt_w(DATA_BITS);
   localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_CNT_W-1:0] BAUD_HALF = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

   uart_state_t            tx_state;
   logic [BAUD_CNT_W-1:0]  tx_cnt;
   logic [BIT_CNT_W-1:0]   tx_bit;
   logic [DATA_BITS-1:0]   tx_shift;
`ifdef UART_PARITY_EN
   logic                   tx_par;
`endif

   always_ff @(posedge clock)
      if (reset) begin
         tx_state   <= IDLE;
         tx_cnt     <= '0;
         tx_bit     <= '0;
         tx_shift   <= '0;
         uart_tx_o  <= 1'b1;
         tx_ready_o <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par     <= 1'b0;
`endif
      end else begin
         tx_cnt <= (tx_state == IDLE || tx_cnt == BAUD_LAST) ? '0 : tx_cnt + 1'b1;
         unique case (tx_state)
            IDLE:
               if (tx_valid_i) begin
                  tx_shift   <= tx_data_i;
                  tx_bit     <= '0;
                  uart_tx_o  <= 1'b0;
                  tx_ready_o <= 1'b0;
                  tx_state   <= START;
`ifdef UART_PARITY_EN
                  tx_par     <= ^tx_data_i;
`endif
               end
            START:
               if (tx_cnt == BAUD_LAST) begin
                  uart_tx_o <= tx_shift[0];
                  tx_shift  <= tx_shift >> 1;
                  tx_state  <= DATA;
               end
            DATA:
               if (tx_cnt == BAUD_LAST) begin
                  tx_bit <= tx_bit + 1'b1;
                  if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                     uart_tx_o <= tx_par;
                     tx_state  <= PARITY;
`else
                     uart_tx_o <= 1'b1;
                     tx_state  <= STOP;
`endif
                  end else begin
                     uart_tx_o <= tx_shift[0];
                     tx_shift  <= tx_shift >> 1;
                  end
               end
            PARITY:
               if (tx_cnt == BAUD_LAST) begin
                  uart_tx_o <= 1'b1;
                  tx_state  <= STOP;
               end
            STOP:
               if (tx_cnt == BAUD_LAST) begin
                  tx_ready_o <= 1'b1;
                  tx_state   <= IDLE;
               end
            default: tx_state <= IDLE;
         endcase
      end

   logic                   rx_s1, rx_s2;
   uart_state_t            rx_state;
   logic [BAUD_CNT_W-1:0]  rx_cnt;
   logic [BIT_CNT_W-1:0]   rx_bit;
   logic [DATA_BITS-1:0]   rx_shift;
   logic                   rx_stop_hit, fifo_push, fifo_full, fifo_empty;
`ifdef UART_PARITY_EN
   logic                   rx_par_bad;
`endif

   assign rx_stop_hit = rx_state == STOP && rx_cnt == BAUD_LAST;
`ifdef UART_PARITY_EN
   assign fifo_push = rx_stop_hit && rx_s2 && !rx_par_bad;
`else
   assign fifo_push = rx_stop_hit && rx_s2;
   assign rx_parity_err_o = 1'b0;
`endif

   always_ff @(posedge clock)
      if (reset) begin
         rx_s1          <= 1'b1;
         rx_s2          <= 1'b1;
         rx_state       <= IDLE;
         rx_cnt         <= '0;
         rx_bit         <= '0;
         rx_shift       <= '0;
         rx_frame_err_o <= 1'b0;
         rx_overrun_o   <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_bad      <= 1'b0;
         rx_parity_err_o <= 1'b0;
`endif
      end else begin
         rx_s1          <= uart_rx_i;
         rx_s2          <= rx_s1;
         rx_frame_err_o <= rx_stop_hit && !rx_s2;
         rx_overrun_o   <= fifo_push && fifo_full && !rx_ready_i;
`ifdef UART_PARITY_EN
         rx_parity_err_o <= rx_stop_hit && rx_par_bad;
`endif
         rx_cnt <= (rx_state == IDLE || rx_cnt == BAUD_LAST) ? '0 : rx_cnt + 1'b1;
         unique case (rx_state)
            IDLE:
               if (!rx_s2) rx_state <= START;
            // half a bit in: a line back high was only a glitch
            START:
               if (rx_cnt == BAUD_HALF) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? IDLE : DATA;
               end
            DATA:
               if (rx_cnt == BAUD_LAST) begin
                  rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                  rx_bit   <= rx_bit + 1'b1;
`ifdef UART_PARITY_EN
                  if (rx_bit == BIT_LAST) rx_state <= PARITY;
`else
                  if (rx_bit == BIT_LAST) rx_state <= STOP;
`endif
               end
            PARITY:
               if (rx_cnt == BAUD_LAST) begin
`ifdef UART_PARITY_EN
                  rx_par_bad <= rx_s2 ^ (^rx_shift);
`endif
                  rx_state   <= STOP;
               end
            STOP:
               if (rx_cnt == BAUD_LAST) rx_state <= IDLE;
            default: rx_state <= IDLE;
         endcase
      end

   uart_rx_fifo #(
      .WIDTH(DATA_BITS),
      .DEPTH(RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clock(clock),
      .reset(reset),
      .push (fifo_push),
      .pop  (rx_ready_i),
      .din  (rx_shift),
      .dout (rx_data_o),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign rx_valid_o = !fifo_empty;

endmodule

// File: tb/tb_uart_port.sv
// tb_uart_port: randomized self-checking bench for uart_port against a frame/queue model.
// Adapts the expected frame to UART_PARITY_EN when defined.
module tb_uart_port;

   localparam int DB    = 8;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NBITS = 2 + DB + P;
   localparam int FRAME = NBITS * CPB;

   logic       clock = 1'b0, reset = 1'b1, rx_line = 1'b1, loopback = 1'b0;
   logic       tx_valid = 1'b0, rx_ready = 1'b0;
   logic [7:0] tx_data = '0;
   logic       uart_tx, uart_rx, tx_ready, rx_valid, rx_ovr, rx_ferr, rx_perr;
   logic [7:0] rx_data;
   int         errors = 0, checks = 0;
   int         n_ovr = 0, n_ferr = 0, n_perr = 0;
   logic [7:0] exp_q[$];

   assign uart_rx = loopback ? uart_tx : rx_line;

   uart_port #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
      .rx_overrun_o(rx_ovr), .rx_frame_err_o(rx_ferr), .rx_parity_err_o(rx_perr)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (rx_ovr) n_ovr++;
      if (rx_ferr) n_ferr++;
      if (rx_perr) n_perr++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // line level of bit idx of a frame: start, data LSB first, even parity, stop
   function automatic logic frame_bit(input logic [7:0] d, input int idx, input logic stop, input logic pflip);
      if (idx == 0) return 1'b0;
      if (idx <= DB) return d[idx-1];
      if (P == 1 && idx == DB + 1) return (^d) ^ pflip;
      return stop;
   endfunction

   // returns at the negedge right after the transfer edge
   task automatic tx_byte(input logic [7:0] b);
      int n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && n < 4 * FRAME) begin
         @(negedge clock);
         n++;
      end
      check("tx_ready_wait", 32'(n < 4 * FRAME), 1);
      @(posedge clock);
      @(negedge clock);
      tx_valid = 1'b0;
   endtask

   task automatic tx_frame_check(input logic [7:0] b);
      int bad = 0, low = 0;
      logic e;
      tx_byte(b);
      check("tx_fall", uart_tx, 0);
      for (int k = 1; k <= FRAME + 1; k++) begin
         if (k > 1) @(negedge clock);
         e = (k <= FRAME) ? frame_bit(b, (k - 1) / CPB, 1'b1, 1'b0) : 1'b1;
         if (uart_tx !== e) bad++;
         if (!tx_ready) low++;
      end
      check("tx_bits", bad, 0);
      check("tx_ready_low", low, FRAME);
      check("tx_ready_back", tx_ready, 1);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop, input logic pflip);
      for (int i = 0; i < NBITS; i++) begin
         rx_line = frame_bit(b, i, stop, pflip);
         repeat (CPB) @(negedge clock);
      end
      rx_line = 1'b1;
   endtask

   task automatic pop_check(input logic [7:0] e);
      check("rx_valid", rx_valid, 1);
      check("rx_data", rx_data, e);
      rx_ready = 1'b1;
      @(negedge clock);
      rx_ready = 1'b0;
   endtask

   task automatic drain_check();
      while (exp_q.size() > 0) pop_check(exp_q.pop_front());
      check("rx_empty", rx_valid, 0);
   endtask

   // model: a stop-valid frame is kept if the buffer has room, else counted as overrun
   task automatic rx_burst(input int cnt, input logic rand_data);
      int ovr = 0, o0 = n_ovr;
      logic [7:0] b;
      for (int i = 0; i < cnt; i++) begin
         b = rand_data ? 8'($urandom) : 8'(i + 1);
         rx_frame(b, 1'b1, 1'b0);
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else ovr++;
      end
      repeat (20) @(negedge clock);
      check("rx_overrun_cnt", n_ovr - o0, ovr);
      drain_check();
   endtask

   initial begin
      int f0, p0, o0, n;
      logic [7:0] b, b2, b3;
      repeat (3) @(negedge clock);
      check("rst_tx", uart_tx, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_flags", {rx_ovr, rx_ferr, rx_perr}, 0);
      reset = 1'b0;
      @(negedge clock);

      tx_frame_check(8'hA5);
      tx_frame_check(8'h07);
      for (int i = 0; i < 3; i++) tx_frame_check(8'($urandom));

      // loopback, back to back
      loopback = 1'b1;
      f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
      exp_q = '{8'h00, 8'hFF, 8'h3C, 8'($urandom)};
      foreach (exp_q[i]) tx_byte(exp_q[i]);
      repeat (FRAME + 30) @(negedge clock);
      drain_check();
      check("loop_errs", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
      loopback = 1'b0;

      rx_burst(5, 1'b0);
      rx_burst(2 + int'($urandom_range(4)), 1'b1);

      // push into empty with pop held: byte appears one cycle then is taken
      b = 8'($urandom);
      rx_ready = 1'b1;
      fork rx_frame(b, 1'b1, 1'b0); join_none
      n = 0;
      while (!rx_valid && n < 3 * FRAME) begin
         @(negedge clock);
         n++;
      end
      check("rx_arrive", 32'(n < 3 * FRAME), 1);
      check("rx_head", rx_data, b);
      @(negedge clock);
      check("rx_autopop", rx_valid, 0);
      wait fork;
      rx_ready = 1'b0;

      f0 = n_ferr;
      rx_frame(8'($urandom), 1'b0, 1'b0);
      repeat (40) @(negedge clock);
      check("frame_err_cnt", n_ferr - f0, 1);
      check("frame_err_nodata", rx_valid, 0);

      f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
      rx_line = 1'b0;
      repeat (5) @(negedge clock);
      rx_line = 1'b1;
      repeat (40) @(negedge clock);
      check("glitch_flags", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
      check("glitch_nodata", rx_valid, 0);

      // reset during TX data bit 4 and RX data bit 3
      b2 = 8'($urandom);
      tx_data = 8'($urandom);
      tx_valid = 1'b1;
      @(posedge clock);
      for (int k = 1; k < 90; k++) begin
         @(negedge clock);
         tx_valid = 1'b0;
         rx_line = (k >= 17) ? frame_bit(b2, (k - 17) / CPB, 1'b1, 1'b0) : 1'b1;
      end
      @(negedge clock);
      reset = 1'b1;
      rx_line = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mid_rst_tx", uart_tx, 1);
      check("mid_rst_ready", tx_ready, 1);
      check("mid_rst_rx_valid", rx_valid, 0);
      repeat (2 * CPB) @(negedge clock);
      check("post_rst_tx_idle", uart_tx, 1);
      b3 = 8'($urandom);
      rx_frame(b3, 1'b1, 1'b0);
      repeat (20) @(negedge clock);
      pop_check(b3);
      check("post_rst_empty", rx_valid, 0);

`ifdef UART_PARITY_EN
      p0 = n_perr;
      rx_frame(8'($urandom), 1'b1, 1'b1);
      repeat (40) @(negedge clock);
      check("parity_err_cnt", n_perr - p0, 1);
      check("parity_nodata", rx_valid, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
